// File: rtl/serial_comp_if.sv
// serial_comp_if: handshake/operand/result bundle for serial_comp.
//   master: drives start, signed_mode, a, b; observes busy/done/flags/steps.
//   slave : the comparator side.
interface serial_comp_if #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
);
    localparam int N  = WIDTH / CHUNK;
    localparam int SW = $clog2(N + 1);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic [SW-1:0]    steps;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, gt, eq, lt, steps
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, gt, eq, lt, steps
    );
endinterface

// File: rtl/serial_comp.sv
// serial_comp: multi-cycle magnitude comparator. Compares two WIDTH-bit
// operands CHUNK bits per clock, most significant chunk first, and stops at
// the first differing chunk. Unsigned or two's-complement mode.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - serial_comp_if.slave: start/signed_mode/a/b in,
//           busy/done/gt/eq/lt/steps out
module serial_comp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_comp_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int SW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
    logic             sm_q, sm_n;
    logic [IW-1:0]    idx_q, idx_n;
    logic [SW-1:0]    steps_q, steps_n;
    logic             gt_q, gt_n, eq_q, eq_n, lt_q, lt_n;
    logic             done_q, done_n;
    logic [CHUNK-1:0] ca, cb;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sm_q    <= 1'b0;
            idx_q   <= '0;
            steps_q <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            a_q     <= a_n;
            b_q     <= b_n;
            sm_q    <= sm_n;
            idx_q   <= idx_n;
            steps_q <= steps_n;
            gt_q    <= gt_n;
            eq_q    <= eq_n;
            lt_q    <= lt_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        a_n     = a_q;
        b_n     = b_q;
        sm_n    = sm_q;
        idx_n   = idx_q;
        steps_n = steps_q;
        gt_n    = gt_q;
        eq_n    = eq_q;
        lt_n    = lt_q;
        done_n  = 1'b0;
        ca      = a_q[idx_q*CHUNK +: CHUNK];
        cb      = b_q[idx_q*CHUNK +: CHUNK];
        // Flipping the sign bit of the top chunk maps two's-complement
        // ordering onto unsigned ordering; lower chunks are magnitude bits.
        if (sm_q && idx_q == IW'(N - 1)) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_n     = bus.a;
                    b_n     = bus.b;
                    sm_n    = bus.signed_mode;
                    idx_n   = IW'(N - 1);
                    steps_n = '0;
                    gt_n    = 1'b0;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                steps_n = steps_q + SW'(1);
                if (ca > cb) begin
                    gt_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (ca < cb) begin
                    lt_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (idx_q == '0) begin
                    eq_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n = idx_q - IW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.gt    = gt_q;
    assign bus.eq    = eq_q;
    assign bus.lt    = lt_q;
    assign bus.steps = steps_q;
endmodule

// File: tb/tb_serial_comp.sv
module tb_serial_comp;
    localparam int WIDTH = 32;
    localparam int CHUNK = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    serial_comp_if #(.WIDTH(WIDTH), .CHUNK(CHUNK)) bus ();

    serial_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sm;
        logic [31:0] a;
        logic [31:0] b;
        logic        gt;
        logic        eq;
        logic        lt;
        int          steps;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.done && lat < 12);
        chk({nm, ".done_seen"}, 32'(bus.done), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = v.sm; bus.a = v.a; bus.b = v.b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({v.name, ".busy0"}, 32'(bus.busy), 32'd1);
        chk({v.name, ".steps0"}, 32'(bus.steps), 32'd0);
        wait_done(v.name, lat);
        chk({v.name, ".latency"}, 32'(lat), 32'(v.steps));
        chk({v.name, ".flags"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, v.gt, v.eq, v.lt});
        chk({v.name, ".steps"}, 32'(bus.steps), 32'(v.steps));
        chk({v.name, ".busy_done"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk({v.name, ".done_1cyc"}, 32'(bus.done), 32'd0);
        chk({v.name, ".hold"}, {29'd0, bus.gt, bus.eq, bus.lt}, {29'd0, v.gt, v.eq, v.lt});
    endtask

    initial begin
        int lat;
        vecs[0]  = '{"u_late_lt",   1'b0, 32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b1, 4};
        vecs[1]  = '{"u_msb_gt",    1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1};
        vecs[2]  = '{"s_msb_lt",    1'b1, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1};
        vecs[3]  = '{"u_eq_dead",   1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4};
        vecs[4]  = '{"s_eq_dead",   1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 4};
        vecs[5]  = '{"u_eq_zero",   1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 4};
        vecs[6]  = '{"s_neg1_lt",   1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1};
        vecs[7]  = '{"u_ff_gt",     1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1};
        vecs[8]  = '{"s_lowchunk",  1'b1, 32'h12FF0000, 32'h12010000, 1'b1, 1'b0, 1'b0, 2};
        vecs[9]  = '{"u_chunk1_lt", 1'b0, 32'h00000100, 32'h00000200, 1'b0, 1'b0, 1'b1, 3};
        vecs[10] = '{"s_min_lt",    1'b1, 32'h80000000, 32'h80000001, 1'b0, 1'b0, 1'b1, 4};

        // Reset with random inputs
        bus.start = 1'($urandom); bus.signed_mode = 1'($urandom);
        bus.a = $urandom; bus.b = $urandom;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.flags", {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
        chk("rst.steps", 32'(bus.steps), 32'd0);
        bus.start = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start pulsed during RUN with other operands is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 32'h1; bus.b = 32'h2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b1; bus.a = 32'hFF000000; bus.b = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ign", lat);
        chk("ign.latency", 32'(lat), 32'd2);
        chk("ign.flags", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b001);
        chk("ign.steps", 32'(bus.steps), 32'd4);

        // back-to-back: start held high through the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 32'h80000000; bus.b = 32'h0;
        @(posedge clk); #1;
        bus.a = 32'd5; bus.b = 32'd3;
        @(posedge clk); #1;
        chk("b2b.done1", 32'(bus.done), 32'd1);
        chk("b2b.flags1", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b100);
        chk("b2b.busy1", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b.busy2", 32'(bus.busy), 32'd1);
        chk("b2b.clr", {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
        chk("b2b.steps_clr", 32'(bus.steps), 32'd0);
        chk("b2b.done_low", 32'(bus.done), 32'd0);
        wait_done("b2b2", lat);
        chk("b2b2.latency", 32'(lat), 32'd4);
        chk("b2b2.flags", {29'd0, bus.gt, bus.eq, bus.lt}, 32'b100);
        chk("b2b2.steps", 32'(bus.steps), 32'd4);

        // reset two cycles into an equal-operand comparison
        @(negedge clk);
        bus.start = 1'b1; bus.signed_mode = 1'b0; bus.a = 32'hDEADBEEF; bus.b = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst.busy", 32'(bus.busy), 32'd0);
        chk("mrst.flags", {29'd0, bus.gt, bus.eq, bus.lt}, 32'd0);
        chk("mrst.steps", 32'(bus.steps), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            repeat (6) begin
                @(posedge clk); #1;
                if (bus.done) seen++;
            end
            chk("mrst.no_done", 32'(seen), 32'd0);
        end
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
